// File: rtl/expr_pkg.sv
// Shared ASCII, operator and state encodings for the expression emitter and recogniser.
package expr_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [CHAR_W-1:0] CH_0    = 8'h30;
  localparam logic [CHAR_W-1:0] CH_PLUS = 8'h2B;
  localparam logic [CHAR_W-1:0] CH_MUL  = 8'h2A;
  localparam logic [CHAR_W-1:0] CH_EQ   = 8'h3D;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIGIT = 3'd1,
    ST_OP    = 3'd2,
    ST_FIN   = 3'd3,
    ST_TERM  = 3'd4
  } state_e;

  function automatic logic [CHAR_W-1:0] digit_char(input logic [DIGIT_W-1:0] d);
    return CH_0 + CHAR_W'(d);
  endfunction

  function automatic logic [CHAR_W-1:0] op_char(input logic op);
    return (op == OP_MUL) ? CH_MUL : CH_PLUS;
  endfunction

endpackage

// File: rtl/expr_char_gen_if.sv
// Valid/ready character stream between the expression emitter and its sink.
interface expr_char_gen_if;
  import expr_pkg::*;

  logic [CHAR_W-1:0] out_char;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_char, output out_valid, input out_ready);
  modport slave  (input out_char, input out_valid, output out_ready);

endinterface

// File: rtl/expr_req_check.sv
// Combinational validation of a request: term count in range and all used digits are BCD.
module expr_req_check
  import expr_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 4,
  parameter int unsigned TW        = 3
) (
  input  logic [DIGIT_W*MAX_TERMS-1:0] i_digits,
  input  logic [TW-1:0]                i_nterms,
  output logic                         o_req_ok
);

  logic w_bad_digit;
  logic w_count_ok;

  always_comb begin
    w_bad_digit = 1'b0;
    for (int i = 0; i < MAX_TERMS; i++) begin
      if ((TW'(i) < i_nterms) && (i_digits[DIGIT_W*i +: DIGIT_W] > 4'd9)) begin
        w_bad_digit = 1'b1;
      end
    end
  end

  assign w_count_ok = (i_nterms != '0) && (i_nterms <= TW'(MAX_TERMS));
  assign o_req_ok   = w_count_ok && !w_bad_digit;

endmodule

// File: rtl/expr_char_gen.sv
// Serialises a captured digit/operator request into an ASCII byte stream over valid/ready.
// Optional macro EXPR_TERM_EN appends a trailing '=' beat after the last digit.
module expr_char_gen
  import expr_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 4,
  parameter int unsigned TW        = 3
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         start,
  input  logic [DIGIT_W*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]         ops,
  input  logic [TW-1:0]                nterms,
  expr_char_gen_if.master              tx,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  state_e                       r_state, w_next_state;
  logic [TW-1:0]                r_idx, w_next_idx;
  logic [DIGIT_W*MAX_TERMS-1:0] r_digits;
  logic [MAX_TERMS-2:0]         r_ops;
  logic [TW-1:0]                r_nterms;
  logic [CHAR_W-1:0]            r_char, w_next_char;
  logic                         r_valid, w_next_valid;
  logic                         r_busy, r_done, r_err, w_next_err;
  logic                         w_capture, w_req_ok, w_xfer;
  logic [DIGIT_W*MAX_TERMS-1:0] w_src_digits;
  logic [MAX_TERMS-2:0]         w_src_ops;
  logic [DIGIT_W-1:0]           w_sel_digit;
  logic                         w_sel_op;

  expr_req_check #(
    .MAX_TERMS (MAX_TERMS),
    .TW        (TW)
  ) u_req_check (
    .i_digits (digits),
    .i_nterms (nterms),
    .o_req_ok (w_req_ok)
  );

  assign w_xfer = r_valid && tx.out_ready;

  // Leaving IDLE the first beat must come straight from the inputs being captured.
  assign w_src_digits = (r_state == ST_IDLE) ? digits : r_digits;
  assign w_src_ops    = (r_state == ST_IDLE) ? ops    : r_ops;

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_capture    = 1'b0;
    w_next_err   = 1'b0;
    w_next_valid = 1'b0;
    w_next_char  = '0;
    w_sel_digit  = '0;
    w_sel_op     = OP_ADD;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          if (w_req_ok) begin
            w_next_state = ST_DIGIT;
            w_next_idx   = '0;
          end else begin
            w_next_err = 1'b1;
          end
        end
      end
      ST_DIGIT: begin
        if (w_xfer) begin
          if (r_idx == r_nterms - TW'(1)) begin
`ifdef EXPR_TERM_EN
            w_next_state = ST_TERM;
`else
            w_next_state = ST_FIN;
`endif
          end else begin
            w_next_state = ST_OP;
          end
        end
      end
      ST_OP: begin
        if (w_xfer) begin
          w_next_idx   = r_idx + TW'(1);
          w_next_state = ST_DIGIT;
        end
      end
      ST_TERM: begin
        if (w_xfer) begin
          w_next_state = ST_FIN;
        end
      end
      ST_FIN: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    for (int i = 0; i < MAX_TERMS; i++) begin
      if (w_next_idx == TW'(i)) begin
        w_sel_digit = w_src_digits[DIGIT_W*i +: DIGIT_W];
      end
    end
    for (int i = 0; i < MAX_TERMS - 1; i++) begin
      if (w_next_idx == TW'(i)) begin
        w_sel_op = w_src_ops[i];
      end
    end

    // Output registers are loaded from the state being entered, keeping latency at one cycle.
    unique case (w_next_state)
      ST_DIGIT: begin
        w_next_valid = 1'b1;
        w_next_char  = digit_char(w_sel_digit);
      end
      ST_OP: begin
        w_next_valid = 1'b1;
        w_next_char  = op_char(w_sel_op);
      end
      ST_TERM: begin
        w_next_valid = 1'b1;
        w_next_char  = CH_EQ;
      end
      default: begin
        w_next_valid = 1'b0;
        w_next_char  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_digits <= '0;
      r_ops    <= '0;
      r_nterms <= '0;
      r_char   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_char  <= w_next_char;
      r_valid <= w_next_valid;
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= (w_next_state == ST_FIN);
      r_err   <= w_next_err;
      if (w_capture) begin
        r_digits <= digits;
        r_ops    <= ops;
        r_nterms <= nterms;
      end
    end
  end

  assign tx.out_char  = r_char;
  assign tx.out_valid = r_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_expr_char_gen.sv
// Scoreboard bench for expr_char_gen: expected characters queued per request, popped on each transfer.
module tb_expr_char_gen;
  import expr_pkg::*;

  localparam int unsigned MAX_TERMS = 4;
  localparam int unsigned TW        = 3;
`ifdef EXPR_TERM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [15:0] digits;
  logic [2:0]  ops;
  logic [2:0]  nterms;
  logic        busy, done, err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb[$];

  expr_char_gen_if u_if ();

  expr_char_gen #(
    .MAX_TERMS (MAX_TERMS),
    .TW        (TW)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .digits (digits),
    .ops    (ops),
    .nterms (nterms),
    .tx     (u_if.master),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic push_expected(input logic [15:0] d, input logic [2:0] o, input int n);
    logic [3:0] dv;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      dv = d[4*i +: 4];
      sb.push_back(8'h30 + {4'h0, dv});
      if (i < n - 1) sb.push_back(o[i] ? 8'h2A : 8'h2B);
    end
    if (EXTRA == 1) sb.push_back(8'h3D);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 plus a stray start mid-stream
  task automatic run_req(input string name, input logic [15:0] d, input logic [2:0] o,
                         input logic [2:0] n, input int mode, input int exp_done);
    int         nbeats;
    int         exp_beats;
    logic [7:0] held;
    logic [7:0] e;
    bit         holding, last_xfer, got_done;
    logic       rdy;
    push_expected(d, o, int'(n));
    exp_beats = sb.size();
    nbeats = 0; holding = 0; last_xfer = 0; got_done = 0;
    start = 1'b1; digits = d; ops = o; nterms = n; u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; digits = ~d; ops = ~o; nterms = n + 3'd1;
    checks++;
    if (u_if.out_valid !== 1'b1) begin
      failures++; $display("FAIL %s first_valid got=%b exp=1", name, u_if.out_valid);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL %s busy_active got=%b exp=1", name, busy);
    end
    for (int cyc = 1; cyc < 200 && !got_done; cyc++) begin
      rdy = (mode == 0) ? 1'b1 : (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3));
      u_if.out_ready = rdy;
      start = (mode == 1 && cyc == 2);
      if (holding) begin
        checks++;
        if (u_if.out_char !== held || u_if.out_valid !== 1'b1) begin
          failures++;
          $display("FAIL %s stall_hold cyc=%0d got=%h/%b exp=%h/1", name, cyc, u_if.out_char, u_if.out_valid, held);
        end
      end
      if (done === 1'b1) begin
        got_done = 1;
        checks++;
        if (!last_xfer || sb.size() != 0 || nbeats != exp_beats) begin
          failures++;
          $display("FAIL %s done_timing beats=%0d exp=%0d remaining=%0d last_xfer=%0d", name, nbeats, exp_beats, sb.size(), last_xfer);
        end
        if (exp_done >= 0) begin
          checks++;
          if (cyc != exp_done) begin
            failures++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, cyc, exp_done);
          end
        end
        checks++;
        if (u_if.out_valid !== 1'b0) begin
          failures++; $display("FAIL %s valid_at_done got=%b exp=0", name, u_if.out_valid);
        end
      end else if (u_if.out_valid === 1'b1) begin
        if (rdy) begin
          checks++;
          if (sb.size() == 0) begin
            failures++; $display("FAIL %s extra_beat got=%h exp=none", name, u_if.out_char);
          end else begin
            e = sb.pop_front();
            if (u_if.out_char !== e) begin
              failures++; $display("FAIL %s beat%0d got=%h exp=%h", name, nbeats, u_if.out_char, e);
            end
          end
          nbeats++; last_xfer = 1; holding = 0;
        end else begin
          held = u_if.out_char; holding = 1; last_xfer = 0;
        end
      end else begin
        checks++;
        if (u_if.out_char !== 8'h00) begin
          failures++; $display("FAIL %s idle_char got=%h exp=00", name, u_if.out_char);
        end
        last_xfer = 0; holding = 0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    u_if.out_ready = 1'b1;
    if (!got_done) begin
      checks++; failures++; $display("FAIL %s timeout got=no_done exp=done", name);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s post_done got=done%b busy%b exp=0/0", name, done, busy);
    end
  endtask

  task automatic reject_one(input string name, input logic [15:0] d, input logic [2:0] n);
    start = 1'b1; digits = d; ops = 3'b000; nterms = n;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || u_if.out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s err_pulse got=err%b valid%b busy%b exp=1/0/0", name, err, u_if.out_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0 || u_if.out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s err_clear got=err%b valid%b busy%b exp=0/0/0", name, err, u_if.out_valid, busy);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b0; digits = '0; ops = '0; nterms = '0; u_if.out_ready = 1'b1;
    #1;
    checks++;
    if (u_if.out_valid !== 1'b0 || u_if.out_char !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=v%b c%h b%b d%b e%b exp=0/00/0/0/0", u_if.out_valid, u_if.out_char, busy, done, err);
    end
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_req("basic_1+2*3", 16'h0321, 3'b010, 3'd3, 0, 6 + EXTRA);
  endtask

  task automatic test_backpressure();
    run_req("stall_1+2*3", 16'h0321, 3'b010, 3'd3, 1, -1);
  endtask

  task automatic test_reject();
    reject_one("rej_n0", 16'h0321, 3'd0);
    reject_one("rej_n5", 16'h0321, 3'd5);
    reject_one("rej_bcd", 16'h000A, 3'd1);
  endtask

  task automatic test_back_to_back();
    run_req("b2b_first", 16'h0321, 3'b010, 3'd3, 0, 6 + EXTRA);
    run_req("b2b_single9", 16'hFFF9, 3'b111, 3'd1, 0, 2 + EXTRA);
  endtask

  task automatic test_max_terms();
    run_req("max_9*0+4*7", 16'h7409, 3'b101, 3'd4, 0, 8 + EXTRA);
  endtask

  task automatic test_midstream_reset();
    bit seen;
    seen = 0;
    start = 1'b1; digits = 16'h0321; ops = 3'b010; nterms = 3'd3; u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (u_if.out_valid === 1'b1 && u_if.out_char === 8'h2A) seen = 1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL midreset_wait got=no_mul_beat exp=2A");
    end
    #2 clr = 1'b0;
    #1;
    checks++;
    if (u_if.out_valid !== 1'b0 || u_if.out_char !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async got=v%b c%h b%b exp=0/00/0", u_if.out_valid, u_if.out_char, busy);
    end
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    run_req("after_reset_5+5", 16'h0055, 3'b000, 3'd2, 0, 4 + EXTRA);
  endtask

  task automatic test_term();
    run_req("term_7*8", 16'h0087, 3'b001, 3'd2, 0, 4 + EXTRA);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reject();
    test_back_to_back();
    test_max_terms();
    test_midstream_reset();
    test_term();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/expr_char_gen.md
Name: expr_char_gen

Overview:
- ASCII expression emitter: serialises a captured request of decimal digits and operators into a byte stream, one character per accepted beat, e.g. "1+2*3".
- Transmit-side counterpart of the expression-string recogniser; its out_char drives the recogniser's 8-bit ASCII input in benches and datapaths.
- Valid/ready output handshake, done/err status pulses.

Parameters:
- MAX_TERMS, 4, maximum operand digits per expression (must be >= 2).
- TW, 3, width of nterms; must satisfy 2**TW > MAX_TERMS.

Ports:
- clk  in  1  single clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- start  in  1  request strobe; sampled only in IDLE
- digits  in  4*MAX_TERMS  BCD operands, term i at [4i+3:4i], term 0 emitted first
- ops  in  MAX_TERMS-1  operator after term i: 0='+' (8'h2B), 1='*' (8'h2A)
- nterms  in  TW  number of terms to emit, 1..MAX_TERMS
- out_char  out  8  ASCII character
- out_valid  out  1  out_char valid
- out_ready  in  1  sink accepts; a beat transfers on out_valid & out_ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the final beat transfers
- err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE, out_valid=0, out_char=8'h00, busy=0, done=0, err=0, index=0. Any in-flight stream is dropped and the next request starts clean.
- States: IDLE, DIGIT, OP, FIN.
- IDLE, start=1: capture digits, ops and nterms into registers.
  - Reject if nterms==0, nterms>MAX_TERMS, or any digit with index < nterms is >9. On reject, err=1 on the next cycle and state stays IDLE.
  - Otherwise move to DIGIT with index=0. The first out_valid is asserted the cycle after start (latency 1).
- DIGIT: out_char = 8'h30 + digit[index], out_valid=1.
  - On transfer, if index==nterms-1 go to FIN; else go to OP.
- OP: out_char = ops[index] ? 8'h2A : 8'h2B, out_valid=1.
  - On transfer, index += 1 and go to DIGIT.
- FIN: out_valid=0, done=1 for exactly one cycle, then IDLE.
- Back-pressure: while out_valid=1 and out_ready=0, out_char and state hold stable. No beat is lost or duplicated.
- start while busy is ignored. Captured registers are not disturbed by input changes after capture.
- Back-to-back requests: the earliest next start is the cycle after done. Minimum emission is one beat per cycle with out_ready tied high.
- Digits and ops at or beyond nterms are don't-care and are never emitted.
- out_char is registered; 8'h00 whenever out_valid=0.
- Total beats per request = 2*nterms-1.

Optional Feature:
- Macro EXPR_TERM_EN.
- Defined: after the last digit transfers, an extra state TERM emits '=' (8'h3D) with the same handshake; FIN follows TERM's transfer. Total beats = 2*nterms.
- Undefined: no TERM state; the stream ends at the last digit.

Decomposition:
- Shared package expr_pkg: ASCII constants (CH_0=8'h30, CH_PLUS=8'h2B, CH_MUL=8'h2A, CH_EQ=8'h3D), state encoding typedef, op encoding constants (OP_ADD=0, OP_MUL=1). The recogniser reuses the same constants.
- One natural sub-module: expr_req_check, combinational validation of nterms and digits producing req_ok. Everything else stays in the top FSM.

Test Plan:
- Start with digits={4'd3,4'd2,4'd1} (terms 0..2 = 1,2,3), ops=2'b10, nterms=3, out_ready=1.
  - Expect beats "1","+","2","*","3" = 31,2B,32,2A,33 on consecutive cycles from cycle 1, then done at cycle 6, busy low after.
- Same request with out_ready toggling 1,0,0,1,...
  - Expect out_char stable across stalls, exactly 5 transfers in order, a single done pulse.
- nterms=0, then nterms=5, then digit0=4'hA with nterms=1.
  - Expect err pulse each time, out_valid never high, busy stays 0.
- nterms=1, digit0=9.
  - Expect single beat 8'h39, then done.
- Drive clr low during the "*" beat.
  - Expect out_valid=0 and out_char=00 immediately without waiting for clk.
  - After release, a new request "5+5" emits 35,2B,35 cleanly.
- With EXPR_TERM_EN defined, request "7*8".
  - Expect 37,2A,38,3D, then done.
  - Feed the stream into the recogniser and check its out asserts for valid strings.
